// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared mode encodings and helpers for the pipelined barrel shifter.
package pipelined_barrel_shifter_pkg;

  localparam int SH_MODE_W = 3;

  typedef enum logic [SH_MODE_W-1:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } sh_mode_e;

  // Encodings above ROR are reserved; such beats pass through unshifted.
  function automatic logic is_reserved(input logic [SH_MODE_W-1:0] mode);
    return mode > SH_ROR;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One log stage: purely combinational shift/rotate by DIST when en is set.
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic                 en,
  input  logic [SH_MODE_W-1:0] mode,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout
);

  // Mode-selected fill; reserved modes and en=0 pass data untouched.
  always_comb begin
    dout = din;
    if (en) begin
      case (mode)
        SH_SLL:  dout = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_SRL:  dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
        SH_SRA:  dout = {{DIST{sign}}, din[WIDTH-1:DIST]};
        SH_ROL:  dout = {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]};
        SH_ROR:  dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-stage barrel shifter: stage k shifts by 2**k when cnt[k] is set,
// one register per stage, valid/ready backpressure and a synchronous flush.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [CNT_W-1:0]     in_cnt,
  input  logic [SH_MODE_W-1:0] in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err
);

  logic [CNT_W-1:0]                vld_pipe;
  logic [CNT_W-1:0]                err_pipe;
  logic [CNT_W-1:0]                sign_pipe;
  logic [CNT_W-1:0][WIDTH-1:0]     data_pipe;
  logic [CNT_W-1:0][WIDTH-1:0]     shifted;
  logic [CNT_W-1:0][CNT_W-1:0]     cnt_pipe;
  logic [CNT_W-1:0][SH_MODE_W-1:0] mode_pipe;
  logic                            advance;

  // Whole pipe moves together; only a held result at the tail stalls it.
  assign advance   = ~(out_valid & ~out_ready);
  assign in_ready  = advance;
  assign out_valid = vld_pipe[CNT_W-1];
  assign out_data  = data_pipe[CNT_W-1];
  assign out_err   = vld_pipe[CNT_W-1] & err_pipe[CNT_W-1];

  // Stage 0 works straight off the inputs; later stages off the previous register.
  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(.WIDTH(WIDTH), .DIST(1)) u_stage (
        .en   (in_cnt[0]),
        .mode (in_mode),
        .sign (in_data[WIDTH-1]),
        .din  (in_data),
        .dout (shifted[0])
      );
    end else begin : g_rest
      shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
        .en   (cnt_pipe[k-1][k]),
        .mode (mode_pipe[k-1]),
        .sign (sign_pipe[k-1]),
        .din  (data_pipe[k-1]),
        .dout (shifted[k])
      );
    end
  end

  // Stage registers: reset beats flush, flush beats stall; payload only moves on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      err_pipe  <= '0;
      sign_pipe <= '0;
      data_pipe <= '0;
      cnt_pipe  <= '0;
      mode_pipe <= '0;
    end else begin
      if (flush)        vld_pipe <= '0;
      else if (advance) vld_pipe <= {vld_pipe[CNT_W-2:0], in_valid};
      if (advance) begin
        data_pipe[0] <= shifted[0];
        cnt_pipe[0]  <= in_cnt;
        mode_pipe[0] <= in_mode;
        sign_pipe[0] <= in_data[WIDTH-1];
        err_pipe[0]  <= is_reserved(in_mode);
        for (int k = 1; k < CNT_W; k++) begin
          data_pipe[k] <= shifted[k];
          cnt_pipe[k]  <= cnt_pipe[k-1];
          mode_pipe[k] <= mode_pipe[k-1];
          sign_pipe[k] <= sign_pipe[k-1];
          err_pipe[k]  <= err_pipe[k-1];
        end
      end
    end
  end

  // Count bits already consumed and the tail's control fields have no reader.
  logic unused_tail;
  assign unused_tail = ^{cnt_pipe, mode_pipe[CNT_W-1], sign_pipe[CNT_W-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH=16 and WIDTH=32.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // WIDTH=16 instance
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [3:0]  in_cnt = '0;
  logic [2:0]  in_mode = '0;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_data;

  // WIDTH=32 instance
  logic        flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic [31:0] in_data_b = '0;
  logic [4:0]  in_cnt_b = '0;
  logic [2:0]  in_mode_b = '0;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] out_data_b;

  pipelined_barrel_shifter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

  pipelined_barrel_shifter #(.WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_cnt(in_cnt_b), .in_mode(in_mode_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_err(out_err_b));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic e; } exp_t;
  exp_t q16[$];
  exp_t q32[$];
  exp_t pe16, pe32;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-by-bit reference: each result bit names the source bit it comes from.
  function automatic logic [31:0] model(input logic [31:0] d, input int c, input int m, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        0:       r[i] = (i >= c)    ? d[i-c] : 1'b0;
        1:       r[i] = (i + c < w) ? d[i+c] : 1'b0;
        2:       r[i] = (i + c < w) ? d[i+c] : d[w-1];
        3:       r[i] = d[(i - c + w) % w];
        4:       r[i] = d[(i + c) % w];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Monitors: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        checks++; fails++;
        $display("FAIL w16_unexpected: got beat %0h expected none", out_data);
      end else begin
        pe16 = q16.pop_front();
        chk("w16_data", 32'(out_data), pe16.d);
        chk("w16_err", 32'(out_err), 32'(pe16.e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      if (q32.size() == 0) begin
        checks++; fails++;
        $display("FAIL w32_unexpected: got beat %0h expected none", out_data_b);
      end else begin
        pe32 = q32.pop_front();
        chk("w32_data", out_data_b, pe32.d);
        chk("w32_err", 32'(out_err_b), 32'(pe32.e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send16(input logic [15:0] d, input logic [3:0] c, input logic [2:0] m,
                        input logic [15:0] ed, input logic ee, input bit push);
    int t;
    in_valid = 1'b1; in_data = d; in_cnt = c; in_mode = m;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send16_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    if (push) q16.push_back('{d: 32'(ed), e: ee});
    #1 in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] c, input logic [2:0] m,
                        input logic [31:0] ed, input logic ee);
    int t;
    in_valid_b = 1'b1; in_data_b = d; in_cnt_b = c; in_mode_b = m;
    t = 0;
    @(negedge clk);
    while (!in_ready_b && t < 300) begin @(negedge clk); t++; end
    if (!in_ready_b) begin
      checks++; fails++;
      $display("FAIL send32_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    q32.push_back('{d: ed, e: ee});
    #1 in_valid_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q16.size() != 0 || q32.size() != 0) && t < 400) begin @(posedge clk); t++; end
    #1;
    chk(name, 32'(q16.size() + q32.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] rv, ex;
    int c, m;

    // Reset state
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid_b", 32'(out_valid_b), 0);
    @(posedge clk); #1;

    // 1: SLL latency
    send16(16'h00F1, 4'd4, 3'b000, 16'h0F10, 1'b0, 1'b1);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("t1_latency", 32'(n), 32'd4);
    @(posedge clk); #1;
    drain("t1_drain");

    // 2: mode sweep
    send16(16'h8421, 4'd5, 3'b001, 16'h0421, 1'b0, 1'b1);
    send16(16'h8421, 4'd5, 3'b010, 16'hFC21, 1'b0, 1'b1);
    send16(16'h8421, 4'd5, 3'b011, 16'h8430, 1'b0, 1'b1);
    send16(16'h8421, 4'd5, 3'b100, 16'h0C21, 1'b0, 1'b1);
    send16(16'h8421, 4'd5, 3'b110, 16'h8421, 1'b1, 1'b1);
    drain("t2_drain");

    // 3: back-to-back SRA sweep, results must come out with no gap
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          ex = (i == 15) ? 32'h0000FFFF : model(32'h8001, i, 2, 16);
          send16(16'h8001, 4'(i), 3'b010, ex[15:0], 1'b0, 1'b1);
        end
      end
      begin
        int w, run;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 40) begin @(negedge clk); w++; end
        run = 0;
        while (out_valid && run < 40) begin run++; @(negedge clk); end
        chk("t3_run_length", 32'(run), 32'd16);
      end
    join
    @(posedge clk); #1;
    drain("t3_drain");

    // 4: backpressure
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send16(16'h0001, 4'(i), 3'b000, 16'(1 << i), 1'b0, 1'b1);
      end
      begin
        cyc(10);
        @(negedge clk);
        chk("t4_in_ready_full", 32'(in_ready), 0);
        chk("t4_out_valid_held", 32'(out_valid), 1);
        chk("t4_out_data_held", 32'(out_data), 32'h0001);
        cyc(3);
        @(negedge clk);
        chk("t4_out_data_frozen", 32'(out_data), 32'h0001);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("t4_drain");

    // 5a: flush with 3 in flight and a new beat offered on the flush cycle
    send16(16'h1111, 4'd1, 3'b000, 16'h0, 1'b0, 1'b0);
    send16(16'h2222, 4'd2, 3'b001, 16'h0, 1'b0, 1'b0);
    send16(16'h3333, 4'd3, 3'b011, 16'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'h4444; in_cnt = 4'd1; in_mode = 3'b000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n = 0;
    repeat (12) begin @(negedge clk); if (out_valid) n++; end
    chk("t5_flush_quiet", 32'(n), 0);
    @(posedge clk); #1;

    // 5b: reset mid-stream
    send16(16'h5555, 4'd1, 3'b000, 16'h0, 1'b0, 1'b0);
    send16(16'h6666, 4'd2, 3'b100, 16'h0, 1'b0, 1'b0);
    send16(16'h7777, 4'd3, 3'b010, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_out_data", 32'(out_data), 0);
    chk("t5_rst_in_ready", 32'(in_ready), 1);
    n = 0;
    repeat (12) begin if (out_valid) n++; @(negedge clk); end
    chk("t5_rst_quiet", 32'(n), 0);
    @(posedge clk); #1;

    // 6: WIDTH=32 ROR latency
    send32(32'h80000001, 5'd31, 3'b100, 32'h00000003, 1'b0);
    n = 1;
    @(negedge clk);
    while (!out_valid_b && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("t6_latency32", 32'(n), 32'd5);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      rv = $urandom; c = $urandom_range(0, 31); m = $urandom_range(0, 7);
      send32(rv, 5'(c), 3'(m), model(rv, c, m, 32), m > 4);
    end
    drain("t6_drain32");

    // Random WIDTH=16 beats under random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rv = $urandom; c = $urandom_range(0, 15); m = $urandom_range(0, 7);
          ex = model(32'(rv[15:0]), c, m, 16);
          send16(rv[15:0], 4'(c), 3'(m), ex[15:0], m > 4, 1'b1);
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("rand16_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
